sdram_port_arbiter: RTL and testbench

//  Shares one SDRAM controller command port between three requesters in the Adam core:

---
 rtl/sdram_port_arbiter.sv | 132 +++++++++++++
 tb/tb_sdram_port_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// Arbitrates three client ports plus periodic auto-refresh onto a single SDRAM
// controller command port, one transaction in flight at a time.
module sdram_port_arbiter #(
  parameter int ADDR_W           = 25,
  parameter int DATA_W           = 16,
  parameter int REFRESH_INTERVAL = 390,
  parameter int MAX_VIDEO_BURST  = 4
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic [2:0]            req,
  input  logic [2:0]            we,
  input  logic [3*ADDR_W-1:0]   addr,
  input  logic [3*DATA_W-1:0]   din,
  input  logic [5:0]            be,
  output logic [2:0]            ack,
  output logic [DATA_W-1:0]     dout,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic                  cmd_refresh,
  output logic                  cmd_we,
  output logic [ADDR_W-1:0]     cmd_addr,
  output logic [DATA_W-1:0]     cmd_din,
  output logic [1:0]            cmd_be,
  input  logic                  rsp_valid,
  input  logic [DATA_W-1:0]     rsp_data,
  output logic                  refresh_miss
);

  localparam int RW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam int VW = (MAX_VIDEO_BURST > 0) ? $clog2(MAX_VIDEO_BURST + 1) : 1;
  localparam logic [RW-1:0] REF_RELOAD = RW'(REFRESH_INTERVAL - 1);
  localparam logic [VW-1:0] VID_MAX    = VW'(MAX_VIDEO_BURST);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RSP, S_REFRESH} state_t;

  state_t          state, state_nxt;
  logic [RW-1:0]   ref_cnt;
  logic            refresh_pend;
  logic            rr_last2;
  logic [VW-1:0]   vid_cnt;
  logic [1:0]      gnt;
  logic [1:0]      win;
  logic            grant_valid;
  logic            p0_ok;
  logic            ref_done;

  // Arbitration is blocked during the ack cycle so a client still holding req
  // on the edge that samples ack is not granted twice.
  always_comb begin
    p0_ok       = req[0] && !((|req[2:1]) && (vid_cnt == VID_MAX));
    grant_valid = (state == S_IDLE) && !refresh_pend && (ack == '0) && (|req);
    ref_done    = (state == S_REFRESH) && cmd_ready;
    win         = 2'd0;
    if (p0_ok)                win = 2'd0;
    else if (req[1] && req[2]) win = rr_last2 ? 2'd1 : 2'd2;
    else if (req[1])          win = 2'd1;
    else                      win = 2'd2;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (refresh_pend)     state_nxt = S_REFRESH;
        else if (grant_valid) state_nxt = S_ISSUE;
      end
      S_ISSUE:    if (cmd_ready) state_nxt = S_WAIT_RSP;
      S_WAIT_RSP: if (rsp_valid) state_nxt = S_IDLE;
      S_REFRESH:  if (cmd_ready) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_valid   = (state == S_ISSUE) || (state == S_REFRESH);
    cmd_refresh = (state == S_REFRESH);
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      ack          <= '0;
      dout         <= '0;
      cmd_we       <= 1'b0;
      cmd_addr     <= '0;
      cmd_din      <= '0;
      cmd_be       <= '0;
      gnt          <= 2'd0;
      rr_last2     <= 1'b1;
      vid_cnt      <= '0;
      ref_cnt      <= REF_RELOAD;
      refresh_pend <= 1'b0;
      refresh_miss <= 1'b0;
    end else begin
      ack <= '0;
      if (state == S_WAIT_RSP && rsp_valid) begin
        ack <= 3'b001 << gnt;
        if (!cmd_we) dout <= rsp_data;
      end

      if (grant_valid) begin
        gnt      <= win;
        cmd_we   <= we[win];
        cmd_addr <= addr[ADDR_W*int'(win) +: ADDR_W];
        cmd_din  <= din[DATA_W*int'(win) +: DATA_W];
        cmd_be   <= be[2*int'(win) +: 2];
        if (win == 2'd0) begin
          if (|req[2:1]) vid_cnt <= vid_cnt + 1'b1;
        end else begin
          vid_cnt  <= '0;
          rr_last2 <= (win == 2'd2);
        end
      end

      // An expiry coinciding with refresh completion re-arms pend without a miss.
      if (ref_cnt == '0) begin
        ref_cnt      <= REF_RELOAD;
        refresh_pend <= 1'b1;
        if (refresh_pend && !ref_done) refresh_miss <= 1'b1;
      end else begin
        ref_cnt <= ref_cnt - 1'b1;
        if (ref_done) refresh_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: single-transaction vector table,
// then multi-cycle sequences for round-robin, video burst cap, refresh and reset.
module tb_sdram_port_arbiter;

  localparam int AW = 25;
  localparam int DW = 16;
  localparam int RI = 390;
  localparam int REF_EV = 9;

  logic            clk_sys = 1'b0;
  logic            reset_n;
  logic [2:0]      req;
  logic [2:0]      we_b;
  logic [3*AW-1:0] addr_b;
  logic [3*DW-1:0] din_b;
  logic [5:0]      be_b;
  logic [2:0]      ack;
  logic [DW-1:0]   dout;
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_refresh;
  logic            cmd_we;
  logic [AW-1:0]   cmd_addr;
  logic [DW-1:0]   cmd_din;
  logic [1:0]      cmd_be;
  logic            rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            refresh_miss;

  int n_chk  = 0;
  int n_fail = 0;
  int log_q[$];

  typedef struct {
    logic [1:0]    port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [1:0]    be;
    logic [DW-1:0] rsp;
    logic [DW-1:0] exp_dout;
  } vec_t;

  vec_t vecs[6];

  sdram_port_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .REFRESH_INTERVAL(RI),
    .MAX_VIDEO_BURST(4)
  ) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .req(req),
    .we(we_b),
    .addr(addr_b),
    .din(din_b),
    .be(be_b),
    .ack(ack),
    .dout(dout),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_refresh(cmd_refresh),
    .cmd_we(cmd_we),
    .cmd_addr(cmd_addr),
    .cmd_din(cmd_din),
    .cmd_be(cmd_be),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .refresh_miss(refresh_miss)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    reset_n   = 1'b0;
    req       = '0;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    cmd_ready = 1'b1;
    repeat (2) @(posedge clk_sys);
    @(negedge clk_sys);
    reset_n = 1'b1;
  endtask

  task automatic set_port(input int p, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [1:0] b);
    we_b[p]             = w;
    addr_b[p*AW +: AW]  = a;
    din_b[p*DW +: DW]   = d;
    be_b[p*2 +: 2]      = b;
  endtask

  // Best-case single transaction: cmd at N+1, rsp at N+2, ack at N+3.
  task automatic do_txn(input vec_t v, input string tag);
    int p;
    p = int'(v.port);
    @(negedge clk_sys);
    addr_b = 75'({$urandom, $urandom, $urandom});
    din_b  = 48'({$urandom, $urandom});
    be_b   = 6'($urandom);
    we_b   = 3'($urandom);
    set_port(p, v.we, v.addr, v.din, v.be);
    req = 3'b001 << p;
    @(posedge clk_sys); #1;
    chk({tag, "_cmd_valid"}, 64'(cmd_valid), 64'd1);
    chk({tag, "_cmd_refresh"}, 64'(cmd_refresh), 64'd0);
    chk({tag, "_cmd_we"}, 64'(cmd_we), 64'(v.we));
    chk({tag, "_cmd_addr"}, 64'(cmd_addr), 64'(v.addr));
    chk({tag, "_cmd_din"}, 64'(cmd_din), 64'(v.din));
    chk({tag, "_cmd_be"}, 64'(cmd_be), 64'(v.be));
    addr_b[p*AW +: AW] = ~v.addr;
    @(posedge clk_sys); #1;
    chk({tag, "_cmd_valid_drop"}, 64'(cmd_valid), 64'd0);
    chk({tag, "_addr_latched"}, 64'(cmd_addr), 64'(v.addr));
    rsp_valid = 1'b1;
    rsp_data  = v.rsp;
    @(posedge clk_sys); #1;
    rsp_valid = 1'b0;
    chk({tag, "_ack"}, 64'(ack), 64'(3'b001 << p));
    chk({tag, "_dout"}, 64'(dout), 64'(v.exp_dout));
    req = '0;
    @(posedge clk_sys); #1;
    chk({tag, "_ack_pulse"}, 64'(ack), 64'd0);
  endtask

  // Acts as a best-case controller and logs acks (port number) and refreshes.
  task automatic serve(input int n_ev, input int budget);
    logic acc;
    for (int c = 0; c < budget && log_q.size() < n_ev; c++) begin
      @(negedge clk_sys);
      acc = cmd_valid && cmd_ready && !cmd_refresh;
      if (cmd_valid && cmd_ready && cmd_refresh) log_q.push_back(REF_EV);
      @(posedge clk_sys); #1;
      rsp_valid = acc;
      rsp_data  = 16'(16'h4000 + c);
      if (ack != '0) begin
        chk("ack_onehot", 64'($onehot(ack)), 64'd1);
        log_q.push_back(ack[0] ? 0 : (ack[1] ? 1 : 2));
      end
    end
    rsp_valid = 1'b0;
    chk("serve_budget", 64'(log_q.size() >= n_ev), 64'd1);
  endtask

  initial begin
    int exp_rr[4];
    int exp_vid[10];
    reset_n   = 1'b0;
    req       = '0;
    we_b      = '0;
    addr_b    = '0;
    din_b     = '0;
    be_b      = '0;
    cmd_ready = 1'b1;
    rsp_valid = 1'b0;
    rsp_data  = '0;

    vecs[0] = '{2'd1, 1'b0, 25'h0000100, 16'h0000, 2'b11, 16'hBEEF, 16'hBEEF};
    vecs[1] = '{2'd2, 1'b1, 25'h1ABCDEF, 16'h1234, 2'b01, 16'h0000, 16'hBEEF};
    vecs[2] = '{2'd0, 1'b0, 25'h0000FFF, 16'h0000, 2'b11, 16'h5A5A, 16'h5A5A};
    vecs[3] = '{2'd1, 1'b1, 25'h1FFFFFF, 16'hFFFF, 2'b10, 16'h7777, 16'h5A5A};
    vecs[4] = '{2'd2, 1'b0, 25'h0000000, 16'h0000, 2'b00, 16'h0001, 16'h0001};
    vecs[5] = '{2'd0, 1'b1, 25'h0123456, 16'hA5A5, 2'b11, 16'h9999, 16'h0001};

    do_reset();
    @(posedge clk_sys); #1;
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    chk("rst_cmd_refresh", 64'(cmd_refresh), 64'd0);
    chk("rst_cmd_addr", 64'(cmd_addr), 64'd0);
    chk("rst_miss", 64'(refresh_miss), 64'd0);

    for (int i = 0; i < 6; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

    // Round-robin between ports 1 and 2, starting with rr_last = port 2.
    do_reset();
    set_port(1, 1'b0, 25'h0000011, 16'h0, 2'b11);
    set_port(2, 1'b0, 25'h0000022, 16'h0, 2'b11);
    req = 3'b110;
    log_q.delete();
    serve(4, 40);
    req = '0;
    exp_rr = '{1, 2, 1, 2};
    for (int i = 0; i < 4; i++)
      chk($sformatf("rr_grant%0d", i), 64'(i < log_q.size() ? log_q[i] : -1), 64'(exp_rr[i]));

    // Video burst cap: four port-0 grants, then port 1 gets one.
    do_reset();
    set_port(0, 1'b0, 25'h0000033, 16'h0, 2'b11);
    set_port(1, 1'b0, 25'h0000011, 16'h0, 2'b11);
    req = 3'b011;
    log_q.delete();
    serve(10, 100);
    req = '0;
    exp_vid = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    for (int i = 0; i < 10; i++)
      chk($sformatf("vid_grant%0d", i), 64'(i < log_q.size() ? log_q[i] : -1), 64'(exp_vid[i]));

    // Refresh becomes pending while port 2 waits for its response.
    do_reset();
    set_port(2, 1'b0, 25'h0000222, 16'h0, 2'b11);
    req = 3'b100;
    @(posedge clk_sys); #1;
    @(posedge clk_sys); #1;
    chk("ref_p2_in_wait", 64'(cmd_valid), 64'd0);
    set_port(0, 1'b0, 25'h0000333, 16'h0, 2'b11);
    req[0] = 1'b1;
    repeat (398) @(posedge clk_sys);
    #1;
    chk("ref_no_preempt", 64'(cmd_valid), 64'd0);
    rsp_valid = 1'b1;
    rsp_data  = 16'hC0DE;
    @(posedge clk_sys); #1;
    rsp_valid = 1'b0;
    chk("ref_p2_ack", 64'(ack), 64'b100);
    chk("ref_p2_dout", 64'(dout), 64'hC0DE);
    req[2] = 1'b0;
    log_q.delete();
    serve(2, 30);
    req = '0;
    chk("ref_order0", 64'(log_q.size() > 0 ? log_q[0] : -1), 64'(REF_EV));
    chk("ref_order1", 64'(log_q.size() > 1 ? log_q[1] : -1), 64'd0);
    chk("ref_no_miss", 64'(refresh_miss), 64'd0);

    // Refresh latency from the counter and the sticky miss flag.
    do_reset();
    cmd_ready = 1'b0;
    repeat (390) @(posedge clk_sys);
    #1;
    chk("ref_pre_valid", 64'(cmd_valid), 64'd0);
    @(posedge clk_sys); #1;
    chk("ref_valid", 64'(cmd_valid), 64'd1);
    chk("ref_refresh", 64'(cmd_refresh), 64'd1);
    repeat (388) @(posedge clk_sys);
    #1;
    chk("miss_before", 64'(refresh_miss), 64'd0);
    chk("ref_held", 64'(cmd_refresh), 64'd1);
    @(posedge clk_sys); #1;
    chk("miss_set", 64'(refresh_miss), 64'd1);
    cmd_ready = 1'b1;
    repeat (20) @(posedge clk_sys);
    #1;
    chk("miss_sticky", 64'(refresh_miss), 64'd1);
    chk("ref_cleared", 64'(cmd_valid), 64'd0);
    do_reset();
    @(posedge clk_sys); #1;
    chk("miss_reset", 64'(refresh_miss), 64'd0);

    // Reset during WAIT_RSP aborts the transaction.
    do_txn(vecs[0], "pre_abort");
    @(negedge clk_sys);
    set_port(1, 1'b1, 25'h0000444, 16'hABCD, 2'b01);
    req = 3'b010;
    @(posedge clk_sys); #1;
    @(posedge clk_sys); #1;
    @(negedge clk_sys);
    reset_n = 1'b0;
    @(posedge clk_sys);
    @(negedge clk_sys);
    reset_n = 1'b1;
    req     = '0;
    @(posedge clk_sys); #1;
    rsp_valid = 1'b1;
    rsp_data  = 16'hDEAD;
    @(posedge clk_sys); #1;
    rsp_valid = 1'b0;
    chk("abort_ack", 64'(ack), 64'd0);
    chk("abort_dout", 64'(dout), 64'd0);
    chk("abort_cmd_valid", 64'(cmd_valid), 64'd0);
    chk("abort_cmd_refresh", 64'(cmd_refresh), 64'd0);
    chk("abort_cmd_we", 64'(cmd_we), 64'd0);
    chk("abort_cmd_addr", 64'(cmd_addr), 64'd0);
    chk("abort_cmd_din", 64'(cmd_din), 64'd0);
    chk("abort_cmd_be", 64'(cmd_be), 64'd0);
    chk("abort_miss", 64'(refresh_miss), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_sys); #1;
      chk($sformatf("abort_no_ack%0d", i), 64'(ack), 64'd0);
    end
    do_txn(vecs[2], "post_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
